julia_dispatch: RTL and testbench

Hands pixel jobs to idle Julia worker blocks. It is the issue side of the worker pool; the result collector drains finished workers on the other side. Each accepted job goes to the next free worker in round-robin order, as a one-cycle one-hot start pulse with the job's address and coordinates broadcast alongside it. The block tracks per-worker busy state until the collector releases the worker.

---
 rtl/julia_dispatch_if.sv | 30 +++
 rtl/julia_dispatch.sv | 115 +++++++++++
 tb/tb_julia_dispatch.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/julia_dispatch_if.sv
// rtl/julia_dispatch_if.sv - job issue, worker start broadcast and worker busy/release bundle
interface julia_dispatch_if #(
    parameter int NUM_BITS = 8,
    parameter int ADDR_W   = 32,
    parameter int COORD_W  = 64
);
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    logic                job_valid;
    logic                job_ready;
    logic [ADDR_W-1:0]   job_address;
    logic [COORD_W-1:0]  job_coord;
    logic [NUM_BITS-1:0] start;
    logic [ADDR_W-1:0]   start_address;
    logic [COORD_W-1:0]  start_coord;
    logic [NUM_BITS-1:0] worker_release;
    logic [NUM_BITS-1:0] busy;
    logic [CNT_W-1:0]    idle_count;
    logic                all_idle;

    modport master (
        output job_valid, job_address, job_coord, worker_release,
        input  job_ready, start, start_address, start_coord, busy, idle_count, all_idle
    );

    modport slave (
        input  job_valid, job_address, job_coord, worker_release,
        output job_ready, start, start_address, start_coord, busy, idle_count, all_idle
    );
endinterface

// File: rtl/julia_dispatch.sv
// rtl/julia_dispatch.sv - round-robin issue of pixel jobs to idle Julia workers
module julia_dispatch #(
    parameter int NUM_BITS = 8,
    parameter int ADDR_W   = 32,
    parameter int COORD_W  = 64
) (
    input  logic              clk,
    input  logic              n_rst,
    julia_dispatch_if.slave   bus
);
    localparam int IDX_W = $clog2(NUM_BITS);
    localparam int CNT_W = $clog2(NUM_BITS + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        ISSUE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NUM_BITS-1:0] busy_q, busy_d;
    logic [NUM_BITS-1:0] start_q, start_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COORD_W-1:0]  coord_q, coord_d;

    logic [NUM_BITS-1:0] set_mask;
    logic [IDX_W-1:0]    free_idx;
    logic                found;
    logic                job_ready;
    logic                xfer;
    logic [CNT_W-1:0]    idle_cnt;
    logic [IDX_W:0]      cand;

    assign job_ready = (state_q == SEARCH) && (busy_q != {NUM_BITS{1'b1}});
    assign xfer      = bus.job_valid && job_ready;

    // First free worker scanning upward from ptr with wrap-around.
    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_BITS)) begin
                cand = cand - (IDX_W+1)'(NUM_BITS);
            end
            if (!found && !busy_q[cand[IDX_W-1:0]]) begin
                found    = 1'b1;
                free_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        addr_d   = addr_q;
        coord_d  = coord_q;
        start_d  = '0;
        set_mask = '0;
        case (state_q)
            SEARCH: begin
                if (xfer) begin
                    set_mask = NUM_BITS'(1) << free_idx;
                    start_d  = NUM_BITS'(1) << free_idx;
                    addr_d   = bus.job_address;
                    coord_d  = bus.job_coord;
                    ptr_d    = (free_idx == IDX_W'(NUM_BITS - 1)) ? '0 : free_idx + IDX_W'(1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = SEARCH;
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
        // Setting after clearing lets a same-cycle accept beat a release.
        busy_d = (busy_q & ~bus.worker_release) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q <= SEARCH;
            ptr_q   <= '0;
            busy_q  <= '0;
            start_q <= '0;
            addr_q  <= '0;
            coord_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            coord_q <= coord_d;
        end
    end

    always_comb begin
        idle_cnt = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            idle_cnt = idle_cnt + CNT_W'(!busy_q[i]);
        end
    end

    assign bus.job_ready     = job_ready;
    assign bus.start         = start_q;
    assign bus.start_address = addr_q;
    assign bus.start_coord   = coord_q;
    assign bus.busy          = busy_q;
    assign bus.idle_count    = idle_cnt;
    assign bus.all_idle      = (busy_q == '0);
endmodule

// File: tb/tb_julia_dispatch.sv
// tb/tb_julia_dispatch.sv - self-checking bench for julia_dispatch
module tb_julia_dispatch;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic n_rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    julia_dispatch_if #(.NUM_BITS(NB), .ADDR_W(32), .COORD_W(64)) bus ();

    julia_dispatch #(.NUM_BITS(NB), .ADDR_W(32), .COORD_W(64)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bit [7:0]    m_busy;
    bit [7:0]    m_start;
    int          m_ptr;
    bit          m_issue;
    logic [31:0] m_addr;
    logic [63:0] m_coord;

    // Reference: free pool as a bit set, scan order as modular arithmetic.
    task automatic step();
        bit [7:0] nb;
        bit [7:0] ns;
        int       s;
        int       nptr;
        bit       niss;
        bit       rdy;
        bit       hit;
        rdy  = !m_issue && (m_busy != 8'hFF);
        nb   = m_busy & ~bus.worker_release;
        ns   = '0;
        nptr = m_ptr;
        niss = 1'b0;
        s    = 0;
        hit  = 1'b0;
        if (n_rst) begin
            nb = '0; nptr = 0; m_addr = '0; m_coord = '0;
        end else if (bus.job_valid && rdy) begin
            for (int k = 0; k < NB; k++) begin
                if (!hit && !m_busy[(m_ptr + k) % NB]) begin
                    hit = 1'b1;
                    s   = (m_ptr + k) % NB;
                end
            end
            nb[s]   = 1'b1;
            ns[s]   = 1'b1;
            nptr    = (s + 1) % NB;
            m_addr  = bus.job_address;
            m_coord = bus.job_coord;
            niss    = 1'b1;
        end
        @(posedge clk);
        m_busy  = nb;
        m_start = ns;
        m_ptr   = nptr;
        m_issue = niss;
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b1;
        bus.job_valid = 1'b0;
        bus.worker_release = '0;
        step();
        n_rst = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        bus.job_valid = 1'b1;
        bus.job_address = 32'hDEADBEEF;
        bus.job_coord = 64'hA5A5_5A5A_1234_5678;
        bus.worker_release = 8'hFF;
        step();
        step();
        n_rst = 1'b0;
        bus.job_valid = 1'b0;
        bus.worker_release = '0;
        n_checks++; if (bus.busy !== 8'h00) begin n_fail++; $display("FAIL reset_busy: got %h want 00", bus.busy); end
        n_checks++; if (bus.start !== 8'h00) begin n_fail++; $display("FAIL reset_start: got %h want 00", bus.start); end
        n_checks++; if (bus.job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.job_ready); end
        n_checks++; if (bus.idle_count !== 4'd8) begin n_fail++; $display("FAIL reset_idle: got %0d want 8", bus.idle_count); end
        n_checks++; if (bus.all_idle !== 1'b1) begin n_fail++; $display("FAIL reset_all_idle: got %b want 1", bus.all_idle); end
        n_checks++; if (bus.start_address !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.start_address); end
    endtask

    task automatic test_single();
        do_reset();
        bus.job_valid = 1'b1;
        bus.job_address = 32'h0000_1000;
        bus.job_coord = 64'h3F800000_BF000000;
        step();
        bus.job_valid = 1'b0;
        n_checks++; if (bus.start !== 8'h01) begin n_fail++; $display("FAIL single_start: got %h want 01", bus.start); end
        n_checks++; if (bus.start_address !== 32'h1000) begin n_fail++; $display("FAIL single_addr: got %h want 1000", bus.start_address); end
        n_checks++; if (bus.start_coord !== 64'h3F800000_BF000000) begin n_fail++; $display("FAIL single_coord: got %h want 3f800000bf000000", bus.start_coord); end
        n_checks++; if (bus.busy !== 8'h01) begin n_fail++; $display("FAIL single_busy: got %h want 01", bus.busy); end
        n_checks++; if (bus.idle_count !== 4'd7) begin n_fail++; $display("FAIL single_idle: got %0d want 7", bus.idle_count); end
        n_checks++; if (bus.job_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_low: got %b want 0", bus.job_ready); end
        step();
        n_checks++; if (bus.start !== 8'h00) begin n_fail++; $display("FAIL single_pulse_width: got %h want 00", bus.start); end
        n_checks++; if (bus.job_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b want 1", bus.job_ready); end
        n_checks++; if (bus.start_address !== 32'h1000) begin n_fail++; $display("FAIL single_addr_hold: got %h want 1000", bus.start_address); end
    endtask

    task automatic test_round_robin();
        bit [7:0] want;
        do_reset();
        bus.job_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            bus.job_address = 32'(k);
            step();
            want = (k % 2 == 1) ? 8'(1 << ((k - 1) / 2)) : 8'h00;
            n_checks++; if (bus.start !== want) begin n_fail++; $display("FAIL rr_start_%0d: got %h want %h", k, bus.start, want); end
        end
        n_checks++; if (bus.busy !== 8'h07) begin n_fail++; $display("FAIL rr_busy: got %h want 07", bus.busy); end
        step();
        bus.job_valid = 1'b0;
        n_checks++; if (bus.start !== 8'h08) begin n_fail++; $display("FAIL rr_ptr3: got %h want 08", bus.start); end
        step();
    endtask

    task automatic test_full_pool();
        do_reset();
        bus.job_valid = 1'b1;
        for (int k = 0; k < 16; k++) step();
        n_checks++; if (bus.busy !== 8'hFF) begin n_fail++; $display("FAIL full_busy: got %h want ff", bus.busy); end
        n_checks++; if (bus.job_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", bus.job_ready); end
        n_checks++; if (bus.idle_count !== 4'd0 || bus.all_idle !== 1'b0) begin n_fail++; $display("FAIL full_idle: got %0d/%b want 0/0", bus.idle_count, bus.all_idle); end
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (bus.start !== 8'h00) begin n_fail++; $display("FAIL full_no_start_%0d: got %h want 00", k, bus.start); end
        end
        bus.worker_release = 8'h20;
        step();
        bus.worker_release = 8'h00;
        n_checks++; if (bus.job_ready !== 1'b1) begin n_fail++; $display("FAIL full_release_ready: got %b want 1", bus.job_ready); end
        n_checks++; if (bus.busy !== 8'hDF) begin n_fail++; $display("FAIL full_release_busy: got %h want df", bus.busy); end
        step();
        bus.job_valid = 1'b0;
        n_checks++; if (bus.start !== 8'h20) begin n_fail++; $display("FAIL full_reuse_start: got %h want 20", bus.start); end
        step();
    endtask

    task automatic test_reselect();
        // Pool is full here; free worker 3, issue to it, then release it right after its pulse.
        bus.worker_release = 8'h08;
        step();
        bus.worker_release = 8'h00;
        bus.job_valid = 1'b1;
        step();
        bus.job_valid = 1'b0;
        n_checks++; if (bus.start !== 8'h08) begin n_fail++; $display("FAIL resel_first: got %h want 08", bus.start); end
        bus.worker_release = 8'h08;
        step();
        bus.worker_release = 8'h00;
        n_checks++; if (bus.busy !== 8'hF7) begin n_fail++; $display("FAIL resel_busy: got %h want f7", bus.busy); end
        n_checks++; if (bus.job_ready !== 1'b1) begin n_fail++; $display("FAIL resel_ready: got %b want 1", bus.job_ready); end
        bus.job_valid = 1'b1;
        step();
        bus.job_valid = 1'b0;
        n_checks++; if (bus.start !== 8'h08) begin n_fail++; $display("FAIL resel_second: got %h want 08", bus.start); end
        step();
    endtask

    task automatic test_wrap_skip();
        do_reset();
        bus.job_valid = 1'b1;
        for (int k = 0; k < 16; k++) step();
        bus.job_valid = 1'b0;
        bus.worker_release = 8'h7F;
        step();
        bus.worker_release = 8'h00;
        bus.job_valid = 1'b1;
        for (int k = 0; k < 14; k++) step();
        bus.job_valid = 1'b0;
        bus.worker_release = 8'h7E;
        step();
        bus.worker_release = 8'h00;
        n_checks++; if (bus.busy !== 8'h81) begin n_fail++; $display("FAIL wrap_busy: got %h want 81", bus.busy); end
        bus.job_valid = 1'b1;
        step();
        bus.job_valid = 1'b0;
        n_checks++; if (bus.start !== 8'h02) begin n_fail++; $display("FAIL wrap_start: got %h want 02", bus.start); end
        step();
    endtask

    task automatic test_edges();
        do_reset();
        bus.worker_release = 8'h10;
        step();
        bus.worker_release = 8'h00;
        n_checks++; if (bus.busy !== 8'h00 || bus.idle_count !== 4'd8) begin n_fail++; $display("FAIL idle_release: got %h/%0d want 00/8", bus.busy, bus.idle_count); end
        bus.job_valid = 1'b1;
        step();
        n_rst = 1'b1;
        bus.job_valid = 1'b0;
        step();
        n_checks++; if (bus.start !== 8'h00) begin n_fail++; $display("FAIL rst_issue_start: got %h want 00", bus.start); end
        n_checks++; if (bus.busy !== 8'h00) begin n_fail++; $display("FAIL rst_issue_busy: got %h want 00", bus.busy); end
        n_rst = 1'b0;
        step();
        n_checks++; if (bus.job_ready !== 1'b1 || bus.all_idle !== 1'b1) begin n_fail++; $display("FAIL rst_issue_ready: got %b/%b want 1/1", bus.job_ready, bus.all_idle); end
    endtask

    task automatic test_random();
        bit exp_ready;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!bus.job_valid || m_start != 0) begin
                bus.job_valid = ($urandom_range(0, 2) != 0);
                bus.job_address = $urandom;
                bus.job_coord = {$urandom, $urandom};
            end
            bus.worker_release = ($urandom_range(0, 2) == 0) ? 8'($urandom & $urandom) : 8'h00;
            step();
            exp_ready = !m_issue && (m_busy != 8'hFF);
            n_checks++; if (bus.start !== m_start) begin n_fail++; $display("FAIL rand_start_%0d: got %h want %h", c, bus.start, m_start); end
            n_checks++; if (bus.busy !== m_busy) begin n_fail++; $display("FAIL rand_busy_%0d: got %h want %h", c, bus.busy, m_busy); end
            n_checks++; if (bus.job_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready_%0d: got %b want %b", c, bus.job_ready, exp_ready); end
            n_checks++; if (bus.idle_count !== 4'(NB - $countones(m_busy))) begin n_fail++; $display("FAIL rand_idle_%0d: got %0d want %0d", c, bus.idle_count, NB - $countones(m_busy)); end
            n_checks++; if (bus.all_idle !== (m_busy == 0)) begin n_fail++; $display("FAIL rand_all_idle_%0d: got %b", c, bus.all_idle); end
            n_checks++; if (bus.start_address !== m_addr || bus.start_coord !== m_coord) begin n_fail++; $display("FAIL rand_data_%0d: got %h/%h want %h/%h", c, bus.start_address, bus.start_coord, m_addr, m_coord); end
        end
        bus.job_valid = 1'b0;
        bus.worker_release = '0;
    endtask

    initial begin
        n_rst = 1'b1;
        bus.job_valid = 1'b0;
        bus.job_address = '0;
        bus.job_coord = '0;
        bus.worker_release = '0;
        m_busy = '0; m_start = '0; m_ptr = 0; m_issue = 1'b0; m_addr = '0; m_coord = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_pool();
        test_reselect();
        test_wrap_skip();
        test_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
